// File: rtl/ahb_matrix_pkg.sv
// ahb_matrix_pkg: shared AHB encodings and default widths for the bus matrix
package ahb_matrix_pkg;
  localparam int AHB_ADDR_WIDTH = 32;
  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;
  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_e;
  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;
endpackage

// File: rtl/ahb_input_stage.sv
// ahb_input_stage: master-side matrix port holding an address phase until the output stage takes it
module ahb_input_stage
  import ahb_matrix_pkg::*;
#(
  parameter int ADDR_WIDTH = AHB_ADDR_WIDTH
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSELS,
  input  logic [ADDR_WIDTH-1:0] HADDRS,
  input  logic [1:0]            HTRANSS,
  input  logic                  HWRITES,
  input  logic [2:0]            HSIZES,
  input  logic [2:0]            HBURSTS,
  input  logic [3:0]            HPROTS,
  input  logic                  HMASTLOCKS,
  input  logic                  HREADYS,
  output logic                  HREADYOUTS,
  output logic                  HRESPS,
  output logic                  req_op,
  output logic                  sel_op,
  output logic [ADDR_WIDTH-1:0] addr_op,
  output logic [1:0]            trans_op,
  output logic                  write_op,
  output logic [2:0]            size_op,
  output logic [2:0]            burst_op,
  output logic [3:0]            prot_op,
  output logic                  mastlock_op,
  input  logic                  active_op,
  input  logic                  readyout_op,
  input  logic                  resp_op
);
  logic                  pend, data_phase;
  logic [ADDR_WIDTH-1:0] h_addr;
  logic [1:0]            h_trans;
  logic                  h_write, h_mastlock;
  logic [2:0]            h_size, h_burst;
  logic [3:0]            h_prot;
  logic                  trans_valid, go, accept;
  assign trans_valid = HSELS & HTRANSS[1] & HREADYS;
  assign go          = active_op & readyout_op;
  assign accept      = go & (pend | trans_valid);
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      pend       <= 1'b0;
      data_phase <= 1'b0;
      h_addr     <= '0;
      h_trans    <= HTRANS_IDLE;
      h_write    <= 1'b0;
      h_size     <= '0;
      h_burst    <= '0;
      h_prot     <= '0;
      h_mastlock <= 1'b0;
    end else begin
      pend       <= (trans_valid & ~go) ? 1'b1 : (pend & go) ? 1'b0 : pend;
      data_phase <= accept ? 1'b1 : readyout_op ? 1'b0 : data_phase;
      if (trans_valid) begin
        h_addr     <= HADDRS;
        h_trans    <= HTRANSS;
        h_write    <= HWRITES;
        h_size     <= HSIZES;
        h_burst    <= HBURSTS;
        h_prot     <= HPROTS;
        h_mastlock <= HMASTLOCKS;
      end
    end
  assign addr_op     = pend ? h_addr : HADDRS;
  assign trans_op    = pend ? h_trans : (HSELS & HREADYS) ? HTRANSS : HTRANS_IDLE;
  assign write_op    = pend ? h_write : HWRITES;
  assign size_op     = pend ? h_size : HSIZES;
  assign burst_op    = pend ? h_burst : HBURSTS;
  assign prot_op     = pend ? h_prot : HPROTS;
  assign mastlock_op = pend ? h_mastlock : HMASTLOCKS;
  assign req_op      = pend | trans_valid;
  assign sel_op      = pend | (HSELS & HREADYS);
  assign HREADYOUTS  = ~pend & (~data_phase | readyout_op);
  assign HRESPS      = data_phase ? resp_op : HRESP_OKAY;
endmodule

// File: tb/tb_ahb_input_stage.sv
// tb_ahb_input_stage: directed self-checking bench for ahb_input_stage
module tb_ahb_input_stage;
  logic        HCLK = 1'b0, HRESETn = 1'b0;
  logic        HSELS, HWRITES, HMASTLOCKS, HREADYS;
  logic [31:0] HADDRS;
  logic [1:0]  HTRANSS;
  logic [2:0]  HSIZES, HBURSTS;
  logic [3:0]  HPROTS;
  logic        HREADYOUTS, HRESPS, req_op, sel_op, write_op, mastlock_op;
  logic [31:0] addr_op;
  logic [1:0]  trans_op;
  logic [2:0]  size_op, burst_op;
  logic [3:0]  prot_op;
  logic        active_op, readyout_op, resp_op;
  int total = 0, bad = 0;
  ahb_input_stage dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS), .HTRANSS(HTRANSS),
    .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS), .HPROTS(HPROTS),
    .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS), .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS),
    .req_op(req_op), .sel_op(sel_op), .addr_op(addr_op), .trans_op(trans_op),
    .write_op(write_op), .size_op(size_op), .burst_op(burst_op), .prot_op(prot_op),
    .mastlock_op(mastlock_op), .active_op(active_op), .readyout_op(readyout_op),
    .resp_op(resp_op)
  );
  always #5 HCLK = ~HCLK;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask
  task automatic beat(input logic [1:0] tr, input logic [31:0] a, input logic w);
    HSELS = 1'b1; HREADYS = 1'b1; HTRANSS = tr; HADDRS = a; HWRITES = w;
  endtask
  task automatic quiet();
    HSELS = 1'b0; HREADYS = 1'b1; HTRANSS = 2'b00; HADDRS = 32'hDEAD_BEEF; HWRITES = 1'b0;
    HSIZES = 3'd2; HBURSTS = 3'd0; HPROTS = 4'h0; HMASTLOCKS = 1'b0;
    active_op = 1'b1; readyout_op = 1'b1; resp_op = 1'b0;
  endtask
  logic [1:0]  bt [5] = '{2'b10, 2'b11, 2'b01, 2'b11, 2'b11};
  logic [31:0] ba [5] = '{32'h100, 32'h104, 32'h108, 32'h108, 32'h10C};
  initial begin
    quiet();
    #3;
    chk("rst_hreadyout", HREADYOUTS, 1);
    chk("rst_hresp", HRESPS, 0);
    chk("rst_req", req_op, 0);
    chk("rst_sel", sel_op, 0);
    chk("rst_trans", trans_op, 0);
    cyc(); HRESETn = 1'b1; cyc();
    // granted pass-through
    beat(2'b10, 32'h2000_0010, 1'b0); #1;
    chk("pt_addr", addr_op, 32'h2000_0010);
    chk("pt_trans", trans_op, 2);
    chk("pt_req", req_op, 1);
    chk("pt_ready", HREADYOUTS, 1);
    cyc(); quiet(); resp_op = 1'b1; #1;
    chk("pt_dphase", HRESPS, 1);
    chk("pt_nopend", req_op, 0);
    chk("pt_idle_trans", trans_op, 0);
    resp_op = 1'b0;
    cyc(); resp_op = 1'b1; #1;
    chk("pt_dphase_clr", HRESPS, 0);
    quiet(); cyc();
    // held request while not granted
    active_op = 1'b0;
    beat(2'b10, 32'h4000_0004, 1'b1); HPROTS = 4'h3; HMASTLOCKS = 1'b1; #1;
    chk("hold_req0", req_op, 1);
    chk("hold_ready0", HREADYOUTS, 1);
    cyc(); quiet(); active_op = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      chk("hold_stall", HREADYOUTS, 0);
      chk("hold_req", req_op, 1);
      chk("hold_addr", addr_op, 32'h4000_0004);
      cyc();
    end
    chk("hold_sel", sel_op, 1);
    chk("hold_trans", trans_op, 2);
    chk("hold_write", write_op, 1);
    chk("hold_prot", prot_op, 3);
    chk("hold_lock", mastlock_op, 1);
    active_op = 1'b1; #1;
    chk("grant_addr", addr_op, 32'h4000_0004);
    chk("grant_stall", HREADYOUTS, 0);
    cyc(); readyout_op = 1'b0; #1;
    chk("grant_follow0", HREADYOUTS, 0);
    chk("grant_noreq", req_op, 0);
    readyout_op = 1'b1; #1;
    chk("grant_follow1", HREADYOUTS, 1);
    chk("grant_live_addr", addr_op, 32'hDEAD_BEEF);
    cyc(); cyc();
    // slave wait states
    beat(2'b10, 32'h3000_0000, 1'b0); #1;
    cyc(); quiet(); HREADYS = 1'b0; readyout_op = 1'b0; #1;
    chk("ws_low1", HREADYOUTS, 0);
    cyc(); #1;
    chk("ws_low2", HREADYOUTS, 0);
    readyout_op = 1'b1; #1;
    chk("ws_high", HREADYOUTS, 1);
    cyc(); readyout_op = 1'b0; #1;
    chk("ws_dphase_clr", HREADYOUTS, 1);
    quiet(); cyc();
    // two-cycle ERROR
    beat(2'b10, 32'h5000_0000, 1'b1); #1;
    cyc(); quiet(); HREADYS = 1'b0; resp_op = 1'b1; readyout_op = 1'b0; #1;
    chk("err1_resp", HRESPS, 1);
    chk("err1_ready", HREADYOUTS, 0);
    cyc(); readyout_op = 1'b1; #1;
    chk("err2_resp", HRESPS, 1);
    chk("err2_ready", HREADYOUTS, 1);
    cyc(); #1;
    chk("err_done", HRESPS, 0);
    quiet(); cyc();
    // INCR4 burst with a BUSY beat
    HBURSTS = 3'd3;
    for (int i = 0; i < 5; i++) begin
      beat(bt[i], ba[i], 1'b0); #1;
      chk("burst_trans", trans_op, bt[i]);
      chk("burst_req", req_op, bt[i] != 2'b01);
      chk("burst_ready", HREADYOUTS, 1);
      chk("burst_addr", addr_op, ba[i]);
      cyc();
    end
    quiet(); cyc(); cyc();
    // granted but slave not ready: phase is held
    readyout_op = 1'b0; beat(2'b10, 32'h6000_0008, 1'b0); #1;
    cyc(); quiet(); readyout_op = 1'b0; #1;
    chk("sim_pend_ready", HREADYOUTS, 0);
    chk("sim_pend_req", req_op, 1);
    chk("sim_pend_addr", addr_op, 32'h6000_0008);
    readyout_op = 1'b1; cyc(); #1;
    chk("sim_release", req_op, 0);
    cyc();
    // asynchronous reset while a phase is held
    active_op = 1'b0; beat(2'b10, 32'h7000_0000, 1'b1); #1;
    cyc(); quiet(); active_op = 1'b0; #1;
    chk("ar_pend", req_op, 1);
    HRESETn = 1'b0; #1;
    chk("ar_req", req_op, 0);
    chk("ar_ready", HREADYOUTS, 1);
    chk("ar_trans", trans_op, 0);
    chk("ar_sel", sel_op, 0);
    cyc(); HRESETn = 1'b1; active_op = 1'b1; #1;
    chk("ar_discard", req_op, 0);
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
